// File: rtl/pipe_hazard_scoreboard_if.sv
// rtl/pipe_hazard_scoreboard_if.sv - ID-stage request and hazard-control response bundle
interface pipe_hazard_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  // Instruction currently decoded in ID
  logic              id_valid;
  logic [REG_AW-1:0] id_rn;
  logic [REG_AW-1:0] id_rm;
  logic              id_rn_used;
  logic              id_rm_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              flush;

  // Hazard-control decisions
  logic              stall;
  logic              issue;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  // Pipeline front end: presents ID contents, consumes decisions
  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           id_rd, id_regwrite, id_is_load, flush,
    input  stall, issue, fwd_a_sel, fwd_b_sel, stall_count
  );

  // Scoreboard side
  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           id_rd, id_regwrite, id_is_load, flush,
    output stall, issue, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - in-flight destination scoreboard driving forwarding, load-use stalls and flushes
module pipe_hazard_scoreboard #(
  parameter int NUM_STAGES   = 3,
  parameter int REG_AW       = 5,
  parameter int ZERO_REG     = 31,
  parameter int LOAD_READY   = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 16
) (
  input logic                     clk_i,
  input logic                     reset_ni,
  pipe_hazard_scoreboard_if.slave hz
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  // Entry k: 1 = EX (youngest) ... NUM_STAGES = oldest tracked stage
  logic              valid_q [1:NUM_STAGES];
  logic [REG_AW-1:0] rd_q    [1:NUM_STAGES];
  logic              rw_q    [1:NUM_STAGES];
  logic              ld_q    [1:NUM_STAGES];
  logic              valid_d [1:NUM_STAGES];
  logic [REG_AW-1:0] rd_d    [1:NUM_STAGES];
  logic              rw_d    [1:NUM_STAGES];
  logic              ld_d    [1:NUM_STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic             a_hit, b_hit, a_load, b_load;
  logic [SEL_W-1:0] a_k, b_k;
  logic             a_haz, b_haz, stall_raw, stall_w, issue_w;

  // Youngest matching producer per operand; scan oldest-first so younger overwrites
  always_comb begin
    a_hit  = 1'b0;
    a_load = 1'b0;
    a_k    = '0;
    b_hit  = 1'b0;
    b_load = 1'b0;
    b_k    = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hz.id_rn_used && (hz.id_rn != REG_AW'(ZERO_REG)) &&
          valid_q[k] && rw_q[k] && (rd_q[k] == hz.id_rn)) begin
        a_hit  = 1'b1;
        a_load = ld_q[k];
        a_k    = SEL_W'(k);
      end
      if (hz.id_rm_used && (hz.id_rm != REG_AW'(ZERO_REG)) &&
          valid_q[k] && rw_q[k] && (rd_q[k] == hz.id_rm)) begin
        b_hit  = 1'b1;
        b_load = ld_q[k];
        b_k    = SEL_W'(k);
      end
    end
  end

  // A load whose data is not yet forwardable forces a bubble; flush overrides it
  always_comb begin
    a_haz     = hz.id_valid && a_hit && a_load && (int'(a_k) < LOAD_READY);
    b_haz     = hz.id_valid && b_hit && b_load && (int'(b_k) < LOAD_READY);
    stall_raw = a_haz || b_haz;
    stall_w   = stall_raw && !hz.flush;
    issue_w   = hz.id_valid && !stall_w && !hz.flush;
  end

  assign hz.stall       = stall_w;
  assign hz.issue       = issue_w;
  assign hz.fwd_a_sel   = a_hit ? a_k : '0;
  assign hz.fwd_b_sel   = b_hit ? b_k : '0;
  assign hz.stall_count = cnt_q;

  // Shift the scoreboard; a flush kills the ID instruction and the youngest FLUSH_STAGES entries
  always_comb begin
    valid_d[1] = issue_w;
    rd_d[1]    = issue_w ? hz.id_rd : '0;
    rw_d[1]    = issue_w && hz.id_regwrite;
    ld_d[1]    = issue_w && hz.id_is_load;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      if (hz.flush && (k <= FLUSH_STAGES + 1)) begin
        valid_d[k] = 1'b0;
        rd_d[k]    = '0;
        rw_d[k]    = 1'b0;
        ld_d[k]    = 1'b0;
      end else begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        rw_d[k]    = rw_q[k-1];
        ld_d[k]    = ld_q[k-1];
      end
    end
  end

  // Saturating count of stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (stall_w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards every in-flight entry at once
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        rw_q[k]    <= 1'b0;
        ld_q[k]    <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        rd_q[k]    <= rd_d[k];
        rw_q[k]    <= rw_d[k];
        ld_q[k]    <= ld_d[k];
      end
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed vector bench for pipe_hazard_scoreboard
module tb_pipe_hazard_scoreboard;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_hazard_scoreboard_if #(.NUM_STAGES(3), .REG_AW(5), .CNT_W(16)) if0 ();
  pipe_hazard_scoreboard_if #(.NUM_STAGES(3), .REG_AW(5), .CNT_W(2))  if1 ();

  pipe_hazard_scoreboard #(
    .NUM_STAGES(3), .REG_AW(5), .ZERO_REG(31), .LOAD_READY(2), .FLUSH_STAGES(1), .CNT_W(16)
  ) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .hz(if0.slave)
  );

  pipe_hazard_scoreboard #(
    .NUM_STAGES(3), .REG_AW(5), .ZERO_REG(31), .LOAD_READY(2), .FLUSH_STAGES(1), .CNT_W(2)
  ) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .hz(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v, rn, rm, rnu, rmu, rd, rw, ld, fl;
    int e_stall, e_issue, chk_fwd, e_a, e_b, e_cnt;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input int v, rn, rm, rnu, rmu, rd, rw, ld, fl,
                              input int es, ei, cf, ea, eb, ec);
    vec_t r;
    r.v = v; r.rn = rn; r.rm = rm; r.rnu = rnu; r.rmu = rmu;
    r.rd = rd; r.rw = rw; r.ld = ld; r.fl = fl;
    r.e_stall = es; r.e_issue = ei; r.chk_fwd = cf; r.e_a = ea; r.e_b = eb; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive0(input vec_t t);
    if0.id_valid    = t.v[0];
    if0.id_rn       = 5'(t.rn);
    if0.id_rm       = 5'(t.rm);
    if0.id_rn_used  = t.rnu[0];
    if0.id_rm_used  = t.rmu[0];
    if0.id_rd       = 5'(t.rd);
    if0.id_regwrite = t.rw[0];
    if0.id_is_load  = t.ld[0];
    if0.flush       = t.fl[0];
  endtask

  task automatic drive1(input int v, input int rn, input int rd, input int ld);
    if1.id_valid    = v[0];
    if1.id_rn       = 5'(rn);
    if1.id_rm       = 5'd0;
    if1.id_rn_used  = 1'b1;
    if1.id_rm_used  = 1'b0;
    if1.id_rd       = 5'(rd);
    if1.id_regwrite = 1'b1;
    if1.id_is_load  = ld[0];
    if1.flush       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_sat [6];

  initial begin
    // v, rn, rm, rnu, rmu, rd, rw, ld, fl | stall, issue, chk_fwd, a, b, cnt
    tbl[0]  = mk(1,  2,  3, 1, 1,  1, 1, 0, 0,  0, 1, 1, 0, 0, 0); // ADDS X1
    tbl[1]  = mk(1,  1,  1, 1, 1,  2, 1, 0, 0,  0, 1, 1, 1, 1, 0); // ADD X2,X1,X1
    tbl[2]  = mk(1,  1,  0, 1, 0,  8, 0, 0, 0,  0, 1, 1, 2, 0, 0); // X1 from MEM
    tbl[3]  = mk(1,  1,  0, 1, 0,  9, 0, 0, 0,  0, 1, 1, 3, 0, 0); // X1 from WB
    tbl[4]  = mk(1,  1,  0, 1, 0,  9, 0, 0, 0,  0, 1, 1, 0, 0, 0); // X1 retired
    tbl[5]  = mk(1, 10,  0, 1, 0,  3, 1, 1, 0,  0, 1, 1, 0, 0, 0); // LDUR X3
    tbl[6]  = mk(1,  3,  5, 1, 1,  4, 1, 0, 0,  1, 0, 0, 0, 0, 0); // load-use stall
    tbl[7]  = mk(1,  3,  5, 1, 1,  4, 1, 0, 0,  0, 1, 1, 2, 0, 1); // retry forwards from MEM
    tbl[8]  = mk(1,  4,  3, 1, 1,  6, 1, 0, 0,  0, 1, 1, 1, 3, 1); // ADD X6; load at WB ok
    tbl[9]  = mk(1,  6,  0, 1, 0,  6, 1, 0, 0,  0, 1, 1, 1, 0, 1); // SUB X6
    tbl[10] = mk(1,  6, 31, 1, 1, 31, 1, 0, 0,  0, 1, 1, 1, 0, 1); // youngest X6 wins
    tbl[11] = mk(1, 31, 31, 1, 1, 13, 1, 0, 0,  0, 1, 1, 0, 0, 1); // XZR never matches
    tbl[12] = mk(1, 20,  0, 1, 0,  7, 1, 1, 0,  0, 1, 1, 0, 0, 1); // LDUR X7
    tbl[13] = mk(1,  7, 13, 1, 1,  8, 1, 0, 1,  0, 0, 0, 0, 0, 1); // flush beats stall
    tbl[14] = mk(1,  7, 13, 1, 1,  8, 0, 0, 0,  0, 1, 1, 0, 3, 1); // X7 killed, X13 survives
    tbl[15] = mk(1, 21,  0, 1, 0,  5, 1, 1, 0,  0, 1, 1, 0, 0, 1); // LDUR X5
    tbl[16] = mk(0,  5,  5, 1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1); // empty ID never stalls
    tbl[17] = mk(1,  5,  5, 1, 1,  0, 0, 0, 0,  0, 1, 1, 2, 2, 1); // both operands from MEM
    tbl[18] = mk(1,  5,  5, 0, 1,  0, 0, 0, 0,  0, 1, 1, 0, 3, 1); // unused rn ignored
    exp_sat[0] = 1; exp_sat[1] = 2; exp_sat[2] = 3;
    exp_sat[3] = 3; exp_sat[4] = 3; exp_sat[5] = 3;

    rst_n = 1'b0;
    drive0(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive1(0, 0, 0, 0);
    #1;
    chk("reset stall", int'(if0.stall), 0);
    chk("reset issue", int'(if0.issue), 1);
    chk("reset fwd_a", int'(if0.fwd_a_sel), 0);
    chk("reset count", int'(if0.stall_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive0(tbl[i]);
      #1;
      chk($sformatf("v%0d stall", i), int'(if0.stall), tbl[i].e_stall);
      chk($sformatf("v%0d issue", i), int'(if0.issue), tbl[i].e_issue);
      chk($sformatf("v%0d count", i), int'(if0.stall_count), tbl[i].e_cnt);
      if (tbl[i].chk_fwd != 0) begin
        chk($sformatf("v%0d fwd_a", i), int'(if0.fwd_a_sel), tbl[i].e_a);
        chk($sformatf("v%0d fwd_b", i), int'(if0.fwd_b_sel), tbl[i].e_b);
      end
      tick();
    end

    // Async reset in the middle of a load-use stall
    drive0(mk(1, 22, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive0(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-reset stall", int'(if0.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset stall", int'(if0.stall), 0);
    chk("mid-reset issue", int'(if0.issue), 1);
    chk("mid-reset fwd_a", int'(if0.fwd_a_sel), 0);
    chk("mid-reset count", int'(if0.stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall", int'(if0.stall), 0);
    tick();
    drive0(mk(1, 4, 4, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post-reset fwd_a", int'(if0.fwd_a_sel), 1);
    chk("post-reset fwd_b", int'(if0.fwd_b_sel), 1);
    tick();

    // Chain of dependent loads on a 2-bit counter: one bubble each, count saturates
    drive1(1, 0, 1, 1);
    tick();
    for (int i = 1; i <= 6; i++) begin
      drive1(1, i, i + 1, 1);
      #1;
      chk($sformatf("sat%0d stall", i), int'(if1.stall), 1);
      tick();
      chk($sformatf("sat%0d count", i), int'(if1.stall_count), exp_sat[i-1]);
      chk($sformatf("sat%0d retry", i), int'(if1.stall), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
